// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch core.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      PAUSE = 2'd1,
      ADJ   = 2'd2
   } state_t;

   typedef logic [3:0] bcd_t;

   // Four display digits as presented to the seven-segment driver.
   typedef struct packed {
      bcd_t min_ten;
      bcd_t min_one;
      bcd_t sec_ten;
      bcd_t sec_one;
   } mmss_t;

   localparam int unsigned SEC_MAX_TEN = 5;
   localparam int unsigned SEC_MAX_ONE = 9;

endpackage

// File: rtl/bcd_pair_counter.sv
// Two-digit BCD counter wrapping from MAX_VAL to 00; carry_c flags the wrapping increment.
module bcd_pair_counter
   import stopwatch_pkg::*;
#(
   parameter int unsigned MAX_VAL = 59
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clear,
   output bcd_t ten,
   output bcd_t one,
   output logic carry_c
);

   localparam bcd_t MAX_TEN = bcd_t'(MAX_VAL / 10);
   localparam bcd_t MAX_ONE = bcd_t'(MAX_VAL % 10);

   bcd_t ten_q, ten_d;
   bcd_t one_q, one_d;
   logic at_max_c;

   assign at_max_c = (ten_q == MAX_TEN) && (one_q == MAX_ONE);
   assign carry_c  = inc && !clear && at_max_c;

   always_comb begin
      ten_d = ten_q;
      one_d = one_q;
      if (clear) begin
         ten_d = '0;
         one_d = '0;
      end else if (inc) begin
         if (at_max_c) begin
            ten_d = '0;
            one_d = '0;
         end else if (one_q == 4'd9) begin
            ten_d = ten_q + 4'd1;
            one_d = '0;
         end else begin
            one_d = one_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ten_q <= '0;
         one_q <= '0;
      end else begin
         ten_q <= ten_d;
         one_q <= one_d;
      end
   end

   assign ten = ten_q;
   assign one = one_q;

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch timekeeping core: RUN/PAUSE/ADJ control over an MM:SS BCD count.
// Optional lap-hold display freeze is built when STOPWATCH_LAP_EN is defined.
module stopwatch_counter
   import stopwatch_pkg::*;
#(
   parameter int unsigned MAX_MIN = 59
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick_1hz,
   input  logic       tick_2hz,
   input  logic       pse,
   input  logic       clr,
   input  logic       adj,
   input  logic       sel,
`ifdef STOPWATCH_LAP_EN
   input  logic       lap,
   output logic       lap_active,
`endif
   output logic [3:0] sec_one,
   output logic [3:0] sec_ten,
   output logic [3:0] min_one,
   output logic [3:0] min_ten,
   output logic       paused,
   output logic       adjusting
);

   state_t state_q, state_d;
   logic   saved_pause_q, saved_pause_d;
   logic   paused_q, paused_d;
   logic   adjusting_q, adjusting_d;

   logic   sec_inc_c;
   logic   adj_min_inc_c;
   logic   run_chain_c;
   logic   min_inc_c;
   logic   sec_carry_c;
   logic   min_carry_c;
   mmss_t  live_c;
   mmss_t  disp_c;

   // Control FSM: clr leaves the state alone; ADJ entry drops any 1 Hz tick that cycle.
   always_comb begin
      state_d       = state_q;
      saved_pause_d = saved_pause_q;
      sec_inc_c     = 1'b0;
      adj_min_inc_c = 1'b0;
      run_chain_c   = 1'b0;
      if (!clr) begin
         unique case (state_q)
            RUN: begin
               if (adj) begin
                  state_d       = ADJ;
                  saved_pause_d = 1'b0;
               end else begin
                  sec_inc_c   = tick_1hz;
                  run_chain_c = 1'b1;
                  if (pse) state_d = PAUSE;
               end
            end
            PAUSE: begin
               if (adj) begin
                  state_d       = ADJ;
                  saved_pause_d = 1'b1;
               end else if (pse) begin
                  state_d = RUN;
               end
            end
            ADJ: begin
               if (!adj) begin
                  state_d = saved_pause_q ? PAUSE : RUN;
               end else if (tick_2hz) begin
                  sec_inc_c     = sel;
                  adj_min_inc_c = !sel;
               end
            end
            default: state_d = RUN;
         endcase
      end
      paused_d    = (state_d == PAUSE);
      adjusting_d = (state_d == ADJ);
   end

   // Minutes advance on the seconds wrap in RUN, or directly when adjusting.
   assign min_inc_c = run_chain_c ? sec_carry_c : adj_min_inc_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= RUN;
         saved_pause_q <= 1'b0;
         paused_q      <= 1'b0;
         adjusting_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         saved_pause_q <= saved_pause_d;
         paused_q      <= paused_d;
         adjusting_q   <= adjusting_d;
      end
   end

   bcd_pair_counter #(
      .MAX_VAL(SEC_MAX_TEN * 10 + SEC_MAX_ONE)
   ) u_sec (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc    (sec_inc_c),
      .clear  (clr),
      .ten    (live_c.sec_ten),
      .one    (live_c.sec_one),
      .carry_c(sec_carry_c)
   );

   bcd_pair_counter #(
      .MAX_VAL(MAX_MIN)
   ) u_min (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc    (min_inc_c),
      .clear  (clr),
      .ten    (live_c.min_ten),
      .one    (live_c.min_one),
      .carry_c(min_carry_c)
   );

`ifdef STOPWATCH_LAP_EN
   logic  lap_active_q, lap_active_d;
   mmss_t hold_q, hold_d;

   // Lap hold toggles on each pulse; clr or ADJ entry always releases it.
   always_comb begin
      lap_active_d = lap_active_q;
      hold_d       = hold_q;
      if (clr || ((state_d == ADJ) && (state_q != ADJ))) begin
         lap_active_d = 1'b0;
      end else if (lap) begin
         lap_active_d = !lap_active_q;
         if (!lap_active_q) hold_d = live_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lap_active_q <= 1'b0;
         hold_q       <= '0;
      end else begin
         lap_active_q <= lap_active_d;
         hold_q       <= hold_d;
      end
   end

   assign disp_c     = lap_active_q ? hold_q : live_c;
   assign lap_active = lap_active_q;
`else
   assign disp_c = live_c;
`endif

   assign sec_one   = disp_c.sec_one;
   assign sec_ten   = disp_c.sec_ten;
   assign min_one   = disp_c.min_one;
   assign min_ten   = disp_c.min_ten;
   assign paused    = paused_q;
   assign adjusting = adjusting_q;

   logic unused_c;
   assign unused_c = min_carry_c;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Scoreboard bench for stopwatch_counter; an integer MM:SS model queues expected outputs per cycle.
module tb_stopwatch_counter;

   localparam int MAX_MIN = 59;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tick_1hz, tick_2hz, pse, clr, adj, sel, lap;
   logic       lap_active;
   logic [3:0] sec_one, sec_ten, min_one, min_ten;
   logic       paused, adjusting;

   int n_checks = 0;
   int n_errors = 0;

   logic [17:0] exp_q[$];
   logic [17:0] got, exp;

   int m_mm, m_ss, m_st, m_sp, h_mm, h_ss;
   bit m_lap;

   always #5 clk = ~clk;

   stopwatch_counter #(.MAX_MIN(MAX_MIN)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick_1hz (tick_1hz),
      .tick_2hz (tick_2hz),
      .pse      (pse),
      .clr      (clr),
      .adj      (adj),
      .sel      (sel),
`ifdef STOPWATCH_LAP_EN
      .lap      (lap),
      .lap_active(lap_active),
`endif
      .sec_one  (sec_one),
      .sec_ten  (sec_ten),
      .min_one  (min_one),
      .min_ten  (min_ten),
      .paused   (paused),
      .adjusting(adjusting)
   );

`ifndef STOPWATCH_LAP_EN
   assign lap_active = 1'b0;
`endif

   // Drive one clock cycle of inputs, advance the model, queue the expected outputs.
   task automatic step(input logic t1, t2, p, c, a, s, l);
      int dmm, dss;
      tick_1hz = t1; tick_2hz = t2; pse = p; clr = c; adj = a; sel = s; lap = l;
      @(posedge clk); #1;
      tick_1hz = 0; tick_2hz = 0; pse = 0; clr = 0; lap = 0;
      if (c) begin
         m_mm = 0; m_ss = 0; m_lap = 0;
      end else begin
         if (l) begin
            if (!m_lap) begin h_mm = m_mm; h_ss = m_ss; end
            m_lap = !m_lap;
         end
         case (m_st)
            0: if (a) begin m_st = 2; m_sp = 0; m_lap = 0; end
               else begin
                  if (t1) begin
                     m_ss++;
                     if (m_ss == 60) begin m_ss = 0; m_mm = (m_mm == MAX_MIN) ? 0 : m_mm + 1; end
                  end
                  if (p) m_st = 1;
               end
            1: if (a) begin m_st = 2; m_sp = 1; m_lap = 0; end
               else if (p) m_st = 0;
            default: if (!a) m_st = m_sp ? 1 : 0;
               else if (t2) begin
                  if (s) m_ss = (m_ss + 1) % 60;
                  else   m_mm = (m_mm == MAX_MIN) ? 0 : m_mm + 1;
               end
         endcase
      end
      dmm = m_lap ? h_mm : m_mm;
      dss = m_lap ? h_ss : m_ss;
      exp_q.push_back({4'(dmm / 10), 4'(dmm % 10), 4'(dss / 10), 4'(dss % 10),
                       1'(m_st == 1), 1'(m_st == 2)});
   endtask

   task automatic model_reset();
      m_mm = 0; m_ss = 0; m_st = 0; m_sp = 0; m_lap = 0; h_mm = 0; h_ss = 0;
   endtask

   task automatic test_reset();
      tick_1hz = 0; tick_2hz = 0; pse = 0; clr = 0; adj = 0; sel = 0; lap = 0;
      rst_n = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({min_ten, min_one, sec_ten, sec_one, paused, adjusting, lap_active} !== 19'h0) begin
         n_errors++;
         $display("FAIL reset: got %h required 0", {min_ten, min_one, sec_ten, sec_one, paused, adjusting, lap_active});
      end
      @(negedge clk) rst_n = 1;
   endtask

   task automatic test_run();
      for (int i = 0; i < 61; i++) begin
         step(1, 0, 0, 0, 0, 0, 0);
         got = {min_ten, min_one, sec_ten, sec_one, paused, adjusting};
         exp = exp_q.pop_front();
         n_checks++;
         if (got !== exp) begin n_errors++; $display("FAIL run[%0d]: got %h required %h", i, got, exp); end
      end
      n_checks++;
      if ({min_ten, min_one, sec_ten, sec_one, paused, adjusting} !== {16'h0101, 2'b00}) begin
         n_errors++; $display("FAIL run_final: got %h%h:%h%h required 01:01", min_ten, min_one, sec_ten, sec_one);
      end
   endtask

   task automatic test_wrap();
      step(0, 0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 59; i++) step(0, 1, 0, 0, 1, 0, 0);
      for (int i = 0; i < 59; i++) step(0, 1, 0, 0, 1, 1, 0);
      step(0, 0, 0, 0, 0, 1, 0);
      while (exp_q.size() > 1) void'(exp_q.pop_front());
      exp = exp_q.pop_front();
      got = {min_ten, min_one, sec_ten, sec_one, paused, adjusting};
      n_checks++;
      if (got !== exp || got !== {16'h5959, 2'b00}) begin
         n_errors++; $display("FAIL wrap_preload: got %h required %h", got, {16'h5959, 2'b00});
      end
      step(1, 0, 0, 0, 0, 0, 0);
      got = {min_ten, min_one, sec_ten, sec_one, paused, adjusting};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp || got !== 18'h0) begin
         n_errors++; $display("FAIL wrap: got %h required %h", got, exp);
      end
   endtask

   task automatic test_pause();
      step(0, 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0, 0);
      while (exp_q.size() > 0) void'(exp_q.pop_front());
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 0, 0, 0, 0, 0);
         got = {min_ten, min_one, sec_ten, sec_one, paused, adjusting};
         exp = exp_q.pop_front();
         n_checks++;
         if (got !== exp || got !== {16'h0010, 2'b10}) begin
            n_errors++; $display("FAIL pause_hold[%0d]: got %h required %h", i, got, exp);
         end
      end
      step(0, 0, 1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      void'(exp_q.pop_front());
      got = {min_ten, min_one, sec_ten, sec_one, paused, adjusting};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp || got !== {16'h0011, 2'b00}) begin
         n_errors++; $display("FAIL pause_resume: got %h required %h", got, exp);
      end
   endtask

   task automatic test_adjust();
      step(0, 0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 1, 0, 0);
      while (exp_q.size() > 1) void'(exp_q.pop_front());
      got = {min_ten, min_one, sec_ten, sec_one, paused, adjusting};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp || got !== {16'h0311, 2'b01}) begin
         n_errors++; $display("FAIL adj_min: got %h required %h", got, {16'h0311, 2'b01});
      end
      for (int i = 0; i < 50; i++) begin
         step(0, 1, 0, 0, 1, 1, 0);
         got = {min_ten, min_one, sec_ten, sec_one, paused, adjusting};
         exp = exp_q.pop_front();
         n_checks++;
         if (got !== exp) begin n_errors++; $display("FAIL adj_sec[%0d]: got %h required %h", i, got, exp); end
      end
      n_checks++;
      if ({min_ten, min_one, sec_ten, sec_one} !== 16'h0301) begin
         n_errors++; $display("FAIL adj_sec_final: got %h%h:%h%h required 03:01", min_ten, min_one, sec_ten, sec_one);
      end
      step(0, 0, 0, 0, 0, 1, 0);
      got = {min_ten, min_one, sec_ten, sec_one, paused, adjusting};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp || got !== {16'h0301, 2'b10}) begin
         n_errors++; $display("FAIL adj_exit: got %h required %h", got, {16'h0301, 2'b10});
      end
   endtask

   task automatic test_clr_priority();
      step(0, 0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 1, 0, 0);
      for (int i = 0; i < 34; i++) step(0, 1, 0, 0, 1, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0, 0);
      while (exp_q.size() > 1) void'(exp_q.pop_front());
      got = {min_ten, min_one, sec_ten, sec_one, paused, adjusting};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp || got !== {16'h1234, 2'b00}) begin
         n_errors++; $display("FAIL clr_setup: got %h required %h", got, {16'h1234, 2'b00});
      end
      step(1, 0, 0, 1, 0, 0, 0);
      got = {min_ten, min_one, sec_ten, sec_one, paused, adjusting};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp || got !== 18'h0) begin
         n_errors++; $display("FAIL clr_tick: got %h required %h", got, exp);
      end
      step(1, 0, 0, 0, 0, 0, 0);
      got = {min_ten, min_one, sec_ten, sec_one, paused, adjusting};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp || got !== {16'h0001, 2'b00}) begin
         n_errors++; $display("FAIL clr_still_run: got %h required %h", got, exp);
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] seq[7] = '{7'b1010000, 7'b0010000, 7'b1000100, 7'b0010100,
                             7'b0100110, 7'b0000000, 7'b1000000};
      for (int i = 0; i < 7; i++) begin
         step(seq[i][6], seq[i][5], seq[i][4], seq[i][3], seq[i][2], seq[i][1], seq[i][0]);
         got = {min_ten, min_one, sec_ten, sec_one, paused, adjusting};
         exp = exp_q.pop_front();
         n_checks++;
         if (got !== exp) begin n_errors++; $display("FAIL b2b[%0d]: got %h required %h", i, got, exp); end
      end
      n_checks++;
      if ({min_ten, min_one, sec_ten, sec_one, paused, adjusting} !== {16'h0004, 2'b00}) begin
         n_errors++; $display("FAIL b2b_final: got %h%h:%h%h required 00:04", min_ten, min_one, sec_ten, sec_one);
      end
   endtask

   task automatic test_reset_mid();
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 1, 0, 0, 1, 0, 0);
      exp_q.delete();
      #2 rst_n = 0;
      #1;
      model_reset();
      n_checks++;
      if ({min_ten, min_one, sec_ten, sec_one, paused, adjusting, lap_active} !== 19'h0) begin
         n_errors++;
         $display("FAIL reset_mid: got %h required 0", {min_ten, min_one, sec_ten, sec_one, paused, adjusting, lap_active});
      end
      adj = 0;
      @(negedge clk) rst_n = 1;
      step(1, 0, 0, 0, 0, 0, 0);
      got = {min_ten, min_one, sec_ten, sec_one, paused, adjusting};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp || got !== {16'h0001, 2'b00}) begin
         n_errors++; $display("FAIL reset_mid_resume: got %h required %h", got, exp);
      end
   endtask

`ifdef STOPWATCH_LAP_EN
   task automatic test_lap();
      step(0, 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1);
      exp_q.delete();
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 0, 0, 0, 0, 0);
         got = {min_ten, min_one, sec_ten, sec_one, paused, adjusting};
         exp = exp_q.pop_front();
         n_checks++;
         if (got !== exp || got !== {16'h0020, 2'b00} || lap_active !== 1'b1) begin
            n_errors++; $display("FAIL lap_hold[%0d]: got %h lap %b required %h lap 1", i, got, lap_active, exp);
         end
      end
      step(0, 0, 0, 0, 0, 0, 1);
      got = {min_ten, min_one, sec_ten, sec_one, paused, adjusting};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp || got !== {16'h0025, 2'b00} || lap_active !== 1'b0) begin
         n_errors++; $display("FAIL lap_release: got %h lap %b required %h lap 0", got, lap_active, exp);
      end
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_run();
      test_wrap();
      test_pause();
      test_adjust();
      test_clr_priority();
      test_back_to_back();
      test_reset_mid();
`ifdef STOPWATCH_LAP_EN
      test_lap();
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
- Timekeeping core of the lab3 stopwatch; sits directly upstream of the 4-digit seven-segment display driver.
- Holds MM:SS as four BCD digits and advances them on a 1 Hz strobe.
- Supports pause, clear and an adjust mode: one field is selected and incremented on a 2 Hz strobe.
- Digit outputs drive the display driver's sec_one/sec_ten/min_one/min_ten inputs; mode flags feed its blink logic.

Parameters:
- MAX_MIN, 59: highest minute value before wrap to 00. Legal range 1..99, decimal.

Ports:
- clk  in  1  system clock; all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- tick_1hz  in  1  one-cycle strobe, 1 Hz, from the clock divider.
- tick_2hz  in  1  one-cycle strobe, 2 Hz, from the clock divider.
- pse  in  1  debounced one-cycle pulse; toggles pause.
- clr  in  1  debounced one-cycle pulse; synchronous clear to 00:00.
- adj  in  1  level; 1 = adjust mode.
- sel  in  1  level; adjust target: 0 = minutes, 1 = seconds.
- sec_one  out  4  BCD seconds units.
- sec_ten  out  4  BCD seconds tens (0..5).
- min_one  out  4  BCD minutes units.
- min_ten  out  4  BCD minutes tens.
- paused  out  1  1 while in PAUSE.
- adjusting  out  1  1 while in ADJ.

Behaviour:
- Reset (rst_n low, async): all digits 0, state RUN, paused=0, adjusting=0, saved_pause=0.
- Outputs are registered. A qualifying strobe in cycle N is visible at the outputs in cycle N+1.
- States:
  - RUN: tick_1hz increments SS. On 59 to 00, MM increments. MM wraps from MAX_MIN to 00, so MAX_MIN:59 becomes 00:00.
  - PAUSE: digits hold; ticks ignored.
  - ADJ: tick_1hz ignored. On tick_2hz, sel=1 increments SS and sel=0 increments MM. Each field wraps independently (SS 59 to 00, MM MAX_MIN to 00) with no carry.
- Transitions:
  - RUN and pse: go to PAUSE.
  - PAUSE and pse: go to RUN.
  - RUN or PAUSE with adj=1: go to ADJ, recording saved_pause = (state==PAUSE).
  - ADJ with adj=0: go to PAUSE if saved_pause, else RUN.
  - pse in ADJ: ignored, saved_pause unchanged.
- Simultaneous events:
  - clr has priority over everything. Digits become 00:00 in any state and the state is unchanged.
  - RUN with pse and tick_1hz together: the increment is applied and the state moves to PAUSE.
  - adj rising with tick_1hz in the same cycle: the state enters ADJ and the tick is dropped.
  - sel change mid-ADJ: takes effect at the next tick_2hz.
- Digits never leave the ranges sec_ten 0..5, sec_one 0..9, min_* per MAX_MIN.
- Reset asserted mid-count or mid-ADJ: immediate return to reset values; no partial update survives.

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- Defined:
  - Adds input lap (debounced 1-cycle pulse) and output lap_active (1 bit).
  - First lap pulse freezes the digit outputs at their current values; lap_active=1; the internal count keeps running.
  - Second lap pulse releases the outputs to the live count next cycle; lap_active=0.
  - clr and entering ADJ both release the lap hold.
  - Reset value of lap_active is 0.
- Undefined: no lap port; outputs always show the live count.

Decomposition:
- Package stopwatch_pkg holds:
  - state enum {RUN, PAUSE, ADJ};
  - 4-bit bcd_t typedef;
  - constants SEC_MAX_TEN=5 and SEC_MAX_ONE=9.
- One sub-module, bcd_pair_counter:
  - two BCD digits, parameterised max value;
  - inputs inc and clear, output carry (1 on the wrap cycle).
  - Instantiated twice, for SS and MM.
  - RUN chains the SS carry into the MM inc; ADJ drives each inc directly.

Test Plan:
- Reset, then 61 tick_1hz strobes in RUN -> digits 01:01, paused=0, adjusting=0.
- Preload 59:59 (adjust), release adj, one tick_1hz -> 00:00.
- pse, 5 tick_1hz, pse, 1 tick_1hz from 00:10 -> paused=1 during hold; ends at 00:11.
- From PAUSE at 00:11:
  - adj=1, sel=0, 3 tick_2hz -> 03:11 (no seconds change from tick_1hz);
  - then sel=1, 50 tick_2hz -> 03:01;
  - then adj=0 -> paused=1.
- clr in the same cycle as tick_1hz at 12:34 in RUN -> 00:00 next cycle, state RUN.
- With STOPWATCH_LAP_EN: lap at 00:20, 5 ticks -> outputs stay 00:20, lap_active=1; second lap -> 00:25.
